// File: rtl/man_ctl_pkg.sv
// man_ctl_pkg: shared types, defaults and helpers for the Manchester TX scheduler.
// Contents: man_tx_state_t frame-sequencer states, default bit timing/width,
// pre_bit() giving the alternating preamble bit (1,0,1,0...) for a bit index.
package man_ctl_pkg;
  localparam int MAN_BIT_CYCLES = 100;
  localparam int MAN_DATA_W = 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_PRE,
    ST_DATA,
    ST_PAR,
    ST_GAP
  } man_tx_state_t;
  function automatic logic pre_bit(input int unsigned idx);
    return (idx % 2) == 0;
  endfunction
endpackage

// File: rtl/man_rr_arbiter.sv
// man_rr_arbiter: combinational round-robin pick, searching upward from last_owner+1 with wrap.
// Ports: req (request vector), last_owner (previous grant), valid (any request), winner (picked index).
module man_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_owner,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] winner
);
  localparam int OW = $clog2(NREQ);
  logic [OW-1:0] k;
  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    valid = 1'b0;
    winner = last_owner;
    k = last_owner;
    for (int i = NREQ; i >= 1; i--) begin
      k = OW'((int'(last_owner) + i) % NREQ);
      if (req[k]) begin
        valid = 1'b1;
        winner = k;
      end
    end
  end
endmodule

// File: rtl/man_tx_scheduler.sv
// man_tx_scheduler: shares one Manchester encoder between NREQ byte streams, emitting
// preamble, MSB-first data and an inter-frame gap as an NRZ bit stream.
// Ports: clk/rst_n (async active-low), req/req_data/req_last/ack (requester handshake),
// enc_bit/enc_en/bit_strobe (encoder side), busy, owner, underrun (status).
// Option: define MAN_TX_PARITY_EN to append an even-parity bit after every byte.
module man_tx_scheduler
  import man_ctl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DATA_W = MAN_DATA_W,
  parameter int BIT_CYCLES = MAN_BIT_CYCLES,
  parameter int PREAMBLE_BITS = 8,
  parameter int GAP_BITS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          ack,
  output logic                     enc_bit,
  output logic                     bit_strobe,
  output logic                     enc_en,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     underrun
);
  localparam int OW = $clog2(NREQ);
  localparam int BW = $clog2(BIT_CYCLES);
  localparam int IW = 16;
  man_tx_state_t state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d, shd_q, shd_d;
  logic last_q, last_d, shd_last_q, shd_last_d, shd_v_q, shd_v_d, par_q, par_d;
  logic [OW-1:0] owner_q, owner_d;
  logic enc_bit_q, enc_en_q, underrun_q, underrun_d;
  logic arb_valid;
  logic [OW-1:0] arb_winner;
  logic timed, strobe, bit_end, final_bit, fetch;
  logic [DATA_W-1:0] data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign data_a[g] = req_data[g*DATA_W +: DATA_W];
  end

  man_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req),
    .last_owner (owner_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  assign timed = state_q inside {ST_PRE, ST_DATA, ST_PAR, ST_GAP};
  assign strobe = timed && bcnt_q == '0;
  assign bit_end = bcnt_q == BW'(BIT_CYCLES - 1);
`ifdef MAN_TX_PARITY_EN
  assign final_bit = state_q == ST_PAR;
`else
  assign final_bit = state_q == ST_DATA && idx_q == IW'(DATA_W - 1);
`endif
  // The next byte is requested at the start of the byte's final bit so it can follow with no idle bit.
  assign fetch = strobe && final_bit && !last_q && req[owner_q];

  always_comb begin
    state_d = state_q;
    bcnt_d = timed ? (bit_end ? '0 : bcnt_q + 1'b1) : '0;
    idx_d = idx_q;
    sh_d = sh_q;
    last_d = last_q;
    par_d = par_q;
    owner_d = owner_q;
    shd_d = shd_q;
    shd_last_d = shd_last_q;
    shd_v_d = shd_v_q;
    underrun_d = 1'b0;
    ack = '0;
    case (state_q)
      ST_IDLE: state_d = |req ? ST_ARB : ST_IDLE;
      ST_ARB: begin
        state_d = arb_valid ? ST_PRE : ST_IDLE;
        if (arb_valid) begin
          ack[arb_winner] = 1'b1;
          owner_d = arb_winner;
          sh_d = data_a[arb_winner];
          last_d = req_last[arb_winner];
          par_d = ^data_a[arb_winner];
          idx_d = '0;
          shd_v_d = 1'b0;
        end
      end
      ST_PRE: if (bit_end) begin
        state_d = idx_q == IW'(PREAMBLE_BITS - 1) ? ST_DATA : ST_PRE;
        idx_d = idx_q == IW'(PREAMBLE_BITS - 1) ? '0 : idx_q + 1'b1;
      end
      ST_DATA: if (bit_end) begin
        sh_d = sh_q << 1;
        idx_d = idx_q + 1'b1;
`ifdef MAN_TX_PARITY_EN
        state_d = idx_q == IW'(DATA_W - 1) ? ST_PAR : ST_DATA;
        idx_d = idx_q == IW'(DATA_W - 1) ? '0 : idx_q + 1'b1;
`endif
      end
      ST_PAR: ;
      ST_GAP: if (bit_end) begin
        state_d = idx_q == IW'(GAP_BITS - 1) ? ST_IDLE : ST_GAP;
        idx_d = idx_q == IW'(GAP_BITS - 1) ? '0 : idx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fetch) begin
      ack[owner_q] = 1'b1;
      shd_d = data_a[owner_q];
      shd_last_d = req_last[owner_q];
      shd_v_d = 1'b1;
    end
    // End of a byte: continue with the shadowed byte, or close the frame (aborting if none was fetched).
    if (bit_end && final_bit) begin
      idx_d = '0;
      if (last_q || !shd_v_q) begin
        state_d = ST_GAP;
        underrun_d = !last_q;
      end else begin
        state_d = ST_DATA;
        sh_d = shd_q;
        last_d = shd_last_q;
        par_d = ^shd_q;
        shd_v_d = 1'b0;
      end
    end
  end

  // Line outputs are computed from next state so they change exactly on entry to a strobe cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bcnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      shd_q <= '0;
      last_q <= 1'b0;
      shd_last_q <= 1'b0;
      shd_v_q <= 1'b0;
      par_q <= 1'b0;
      owner_q <= OW'(NREQ - 1);
      enc_bit_q <= 1'b0;
      enc_en_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      shd_q <= shd_d;
      last_q <= last_d;
      shd_last_q <= shd_last_d;
      shd_v_q <= shd_v_d;
      par_q <= par_d;
      owner_q <= owner_d;
      enc_bit_q <= state_d == ST_PRE ? pre_bit(32'(idx_d)) :
                   state_d == ST_DATA ? sh_d[DATA_W-1] :
                   state_d == ST_PAR ? par_d : 1'b0;
      enc_en_q <= state_d inside {ST_PRE, ST_DATA, ST_PAR};
      underrun_q <= underrun_d;
    end

  assign enc_bit = enc_bit_q;
  assign enc_en = enc_en_q;
  assign bit_strobe = strobe;
  assign busy = state_q != ST_IDLE;
  assign owner = owner_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_man_tx_scheduler.sv
// tb_man_tx_scheduler: scoreboard bench for man_tx_scheduler (honours MAN_TX_PARITY_EN).
module tb_man_tx_scheduler;
  localparam int PRE = 8, GAP = 2, BC = 100, DW = 8;
`ifdef MAN_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req = '0, req_last = '0, ack;
  logic [31:0] req_data = '0;
  logic enc_bit, bit_strobe, enc_en, busy, underrun;
  logic [1:0] owner;
  int checks = 0, failures = 0;
  logic exp_bits[$];
  int exp_own[$];
  logic [8:0] rmem [4][16];
  int rhead[4], rtail[4];
  logic [3:0] ack_seen = '0;
  logic mon_en = 1'b0;
  int gap_cnt = 0, ucnt = 0, fetch_cnt = 0, extra = 0;

  always #5 clk = ~clk;

  man_tx_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .enc_bit(enc_bit), .bit_strobe(bit_strobe), .enc_en(enc_en),
    .busy(busy), .owner(owner), .underrun(underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic l);
    rmem[r][rtail[r]] = {l, d};
    rtail[r]++;
  endtask

  task automatic exp_frame(input int o);
    exp_own.push_back(o);
    for (int i = 0; i < PRE; i++) exp_bits.push_back(i % 2 == 0);
  endtask

  task automatic exp_byte(input logic [7:0] d);
    for (int b = 7; b >= 0; b--) exp_bits.push_back(d[b]);
    if (PB != 0) exp_bits.push_back(^d);
  endtask

  task automatic clear_cnt();
    gap_cnt = 0; ucnt = 0; fetch_cnt = 0; extra = 0;
  endtask

  task automatic finish_frame(input string tag, input int frames, input int ue, input int fe);
    check({tag, "_gap_bits"}, 32'(gap_cnt), frames * GAP);
    check({tag, "_underruns"}, 32'(ucnt), ue);
    check({tag, "_fetch_acks"}, 32'(fetch_cnt), fe);
    check({tag, "_bits_left"}, 32'(exp_bits.size()), 0);
    check({tag, "_grants_left"}, 32'(exp_own.size()), 0);
    check({tag, "_unexpected"}, 32'(extra), 0);
    clear_cnt();
  endtask

  task automatic run_single(input string tag, input int bytes, input int ue, input int fe);
    int n = 0;
    while (!(bit_strobe && enc_en) && n < 50) begin @(negedge clk); n++; end
    check({tag, "_start"}, 32'(bit_strobe && enc_en), 1);
    n = 0;
    while (busy && n < 6000) begin @(negedge clk); n++; end
    check({tag, "_len"}, 32'(n), (PRE + bytes * (DW + PB) + GAP) * BC);
    finish_frame(tag, 1, ue, fe);
  endtask

  task automatic wait_all(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy || |req) && n < budget) begin @(negedge clk); n++; end
    check({tag, "_drained"}, 32'({busy, |req}), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_enc_bit"}, 32'(enc_bit), 0);
    check({tag, "_strobe"}, 32'(bit_strobe), 0);
    check({tag, "_enc_en"}, 32'(enc_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_owner"}, 32'(owner), 3);
    check({tag, "_underrun"}, 32'(underrun), 0);
  endtask

  // Requesters: present the head of each byte queue and advance after an ack.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ack_seen[i] && rhead[i] != rtail[i]) rhead[i]++;
      req[i] = rhead[i] != rtail[i];
      req_data[i*8 +: 8] = rmem[i][rhead[i]][7:0];
      req_last[i] = rmem[i][rhead[i]][8];
    end
  end

  // Monitor: pops the scoreboard at every enabled strobe and checks every ack.
  initial forever begin
    @(negedge clk);
    ack_seen = ack;
    if (mon_en) begin
      if (bit_strobe && enc_en) begin
        if (exp_bits.size() == 0) extra++;
        else check("line_bit", 32'(enc_bit), 32'(exp_bits.pop_front()));
      end
      if (bit_strobe && !enc_en && busy) gap_cnt++;
      if (|ack && enc_en) begin
        fetch_cnt++;
        check("fetch_on_strobe", 32'(bit_strobe), 1);
      end
      if (|ack && !enc_en) begin
        if (exp_own.size() == 0) extra++;
        else check("arb_grant", 32'(ack), 32'(1) << exp_own.pop_front());
      end
      if (underrun) begin
        ucnt++;
        check("underrun_in_gap", 32'({bit_strobe, enc_en}), 2);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    push_byte(0, 8'hA5, 1'b1); exp_frame(0); exp_byte(8'hA5);
    n = 0;
    while (!req[0] && n < 10) begin @(negedge clk); n++; end
    check("lat_idle_busy", 32'(busy), 0);
    @(negedge clk);
    check("lat_arb", 32'({busy, enc_en, bit_strobe}), 4);
    @(negedge clk);
    check("lat_first_strobe", 32'({bit_strobe, enc_en}), 3);
    run_single("a5", 1, 0, 0);
    check("a5_owner", 32'(owner), 0);
    push_byte(0, 8'h07, 1'b1); exp_frame(0); exp_byte(8'h07);
    run_single("b07", 1, 0, 0);
    push_byte(1, 8'h11, 1'b1); push_byte(1, 8'h12, 1'b1);
    push_byte(2, 8'h21, 1'b1); push_byte(2, 8'h22, 1'b1);
    exp_frame(1); exp_byte(8'h11); exp_frame(2); exp_byte(8'h21);
    exp_frame(1); exp_byte(8'h12); exp_frame(2); exp_byte(8'h22);
    wait_all("rr", 9000);
    finish_frame("rr", 4, 0, 0);
    check("rr_owner", 32'(owner), 2);
    push_byte(3, 8'h01, 1'b0); push_byte(3, 8'h80, 1'b0); push_byte(3, 8'hFF, 1'b1);
    exp_frame(3); exp_byte(8'h01); exp_byte(8'h80); exp_byte(8'hFF);
    run_single("multi", 3, 0, 2);
    push_byte(2, 8'h3C, 1'b0); exp_frame(2); exp_byte(8'h3C);
    run_single("urun", 1, 1, 0);
    check("urun_owner", 32'(owner), 2);
    push_byte(0, 8'hFF, 1'b1); exp_frame(0); exp_byte(8'hFF);
    n = 0;
    while (!(bit_strobe && enc_en) && n < 50) begin @(negedge clk); n++; end
    repeat ((PRE + 3) * BC + 50) @(negedge clk);
    check("mid_busy", 32'({busy, enc_en}), 3);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    exp_bits.delete();
    exp_own.delete();
    clear_cnt();
    repeat (3) @(negedge clk);
    check("midrst_hold_busy", 32'(busy), 0);
    push_byte(0, 8'h96, 1'b1); exp_frame(0); exp_byte(8'h96);
    mon_en = 1'b1;
    rst_n = 1'b1;
    run_single("restart", 1, 0, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_byte(i, 8'(8'h40 + i), 1'b1);
      exp_frame(i);
      exp_byte(8'(8'h40 + i));
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_all("all4", 12000);
    finish_frame("all4", 4, 0, 0);
    check("all4_owner", 32'(owner), 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/man_tx_scheduler.md
# man_tx_scheduler

Bit-rate scheduler that shares one Manchester encoder/line between `NREQ` byte-stream requesters. It arbitrates round-robin per frame and fetches bytes from the winning requester. It emits preamble, data and inter-frame gap as an NRZ bit stream with a per-bit strobe and encoder enable. The Manchester encoder sits directly downstream and encodes `enc_bit` while `enc_en` is high; the line idles otherwise.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: byte width, sent MSB first.
- `BIT_CYCLES`, 100: clk cycles per bit (100 × 10 ns = 1 Mb/s); ≥ 4.
- `PREAMBLE_BITS`, 8: alternating preamble length, first bit 1; even, ≥ 2.
- `GAP_BITS`, 2: idle bit periods after every frame or abort; ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in NREQ: requester i has a byte on its `req_data` slice.
- `req_data` in NREQ*DATA_W: slice i = bits [i*DATA_W +: DATA_W].
- `req_last` in NREQ: the presented byte is the last of its frame.
- `ack` out NREQ: one-hot, 1-cycle pulse when the byte is latched; requester then advances.
- `enc_bit` out 1: NRZ bit to the encoder.
- `bit_strobe` out 1: 1-cycle pulse at every bit boundary while not IDLE.
- `enc_en` out 1: encoder enable, high during PREAMBLE/DATA(/PARITY).
- `busy` out 1: state ≠ IDLE.
- `owner` out $clog2(NREQ): current or last granted requester.
- `underrun` out 1: 1-cycle pulse on mid-frame abort.

## Operation
- States: IDLE → ARB → PREAMBLE → DATA (→ PARITY) → GAP → IDLE.
- IDLE: when any `req` is high, go to ARB next cycle.
- ARB (1 cycle):
  - Pick the first requester with `req` high, searching from `owner+1` upward with wrap.
  - After reset, `owner` = NREQ-1, so req[0] has top priority.
  - Pulse `ack[winner]`; latch its data and last flag into the shift register.
  - Grant is held for the whole frame.
- Bit timer `bcnt` counts 0..BIT_CYCLES-1. `bit_strobe` = (`bcnt`==0) in PREAMBLE/DATA/PARITY/GAP.
- PREAMBLE: `PREAMBLE_BITS` bits, pattern 1,0,1,0…; then DATA.
- DATA: shifts out `DATA_W` bits MSB first. At the `bit_strobe` of the final bit:
  - last flag set → leave DATA after this bit, to GAP (or PARITY).
  - else `req[owner]` high → pulse `ack[owner]`, latch the next byte into the shadow register; it starts at the next boundary with no idle bit.
  - else → after this bit, pulse `underrun`, go to GAP, frame aborted.
- GAP: `GAP_BITS` bit periods with `enc_en`=0, `enc_bit`=0; then IDLE.
- A `req` that drops before ARB loses no data.
- Requests from other sources during a frame wait until IDLE→ARB.
- `req` rising in the same cycle that GAP ends is seen in IDLE one cycle later.

## Timing
- Reset values: `ack`=0, `enc_bit`=0, `bit_strobe`=0, `enc_en`=0, `busy`=0, `owner`=NREQ-1, `underrun`=0, state IDLE, `bcnt`=0.
- `rst_n` asserted mid-frame: all outputs return to reset values immediately. No ack is pending and no byte is replayed.
- Latency: `req` high in cycle t (IDLE) → ARB in t+1 with `ack` → first preamble `bit_strobe`, `enc_en`=1 in t+2.
- `enc_bit` and `enc_en` change only in the cycle `bit_strobe` is high (registered outputs). The exception is `enc_en` falling on entry to GAP, which also coincides with a strobe.
- Frame length for k bytes:
  - without parity: (PREAMBLE_BITS + k·DATA_W + GAP_BITS)·BIT_CYCLES cycles, from first strobe to IDLE.
  - with parity: add k bit periods.
- `ack` never pulses in PREAMBLE, GAP or IDLE, except the ARB pulse.

## Configuration
- `MAN_TX_PARITY_EN` defined:
  - After each byte, PARITY state sends one even-parity bit (XOR of the byte).
  - The next-byte fetch and the underrun decision move to the parity bit's strobe.
- Not defined: no PARITY state; bytes are back-to-back.

## Structure
- Package `man_ctl_pkg`:
  - state enum `man_tx_state_t`.
  - function computing the preamble bit from its index.
  - default localparams `MAN_BIT_CYCLES`=100, `MAN_DATA_W`=8.
- Sub-module `man_rr_arbiter`:
  - combinational round-robin pick.
  - inputs `req`, `last_owner`; outputs `valid`, `winner`.
  - instantiated once.

## Test plan
- Single requester, req[0] one byte 0xA5 with last=1 → ack[0] in ARB; preamble 10101010 then 1,0,1,0,0,1,0,1 at 100-cycle strobes; 2 gap bits; IDLE 1800 cycles after first strobe.
- req[1], req[2] held continuously, each sending 1-byte frames → owners alternate 1,2,1,2; after reset with all four requesting, the first owner is 0.
- Requester 3 sends a 3-byte frame 0x01,0x80,0xFF → ack pulses at the final-bit strobe of bytes 1 and 2; 24 contiguous data bits; no gap between bytes.
- Requester drops `req` before the second byte → `underrun` one pulse after byte 1's last bit; `enc_en` low; 2 gap bits; IDLE.
- `rst_n` low for 3 cycles during the 4th data bit → outputs at reset values within the same cycle; after release with req[0] high, a normal frame restarts via ARB.
- With `MAN_TX_PARITY_EN`, byte 0x07 → bits 00000111 then parity 1; frame length 1900 cycles.
